// File: rtl/pad_conditioner_if.sv
// Pad-side and console-side signal bundle for pad_conditioner.
interface pad_conditioner_if;
  logic        sample_en;
  logic [15:0] pad_buttons;
  logic        pad_connect;
  logic [7:0]  buttons;
  logic        connected;
  logic        combo_reset;

  modport master (
    output sample_en,
    output pad_buttons,
    output pad_connect,
    input  buttons,
    input  connected,
    input  combo_reset
  );

  modport slave (
    input  sample_en,
    input  pad_buttons,
    input  pad_connect,
    output buttons,
    output connected,
    output combo_reset
  );
endinterface

// File: rtl/pad_conditioner.sv
// DUALSHOCK word debounce, NES remap and L1+R1+L2+R2 console reset combo.
// Optional turbo on tri/sq: define PAD_CONDITIONER_TURBO_EN.
module pad_conditioner #(
  parameter int DEB_TICKS   = 4,
  parameter int HOLD_TICKS  = 500,
  parameter int RESET_TICKS = 16,
  parameter int TURBO_DIV   = 33
) (
  input logic clk,
  input logic n_reset,
  pad_conditioner_if.slave pad
);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    FIRE,
    WAIT_REL
  } state_t;

  localparam logic [3:0]  DEB_LAST = 4'(DEB_TICKS - 1);
  localparam logic [16:0] HOLD_END = 17'(HOLD_TICKS);
  localparam logic [16:0] RST_END  = 17'(RESET_TICKS);

  logic [15:0] raw;
  logic        conn_q;
  logic        smp;
  logic [15:0] deb;
  logic [3:0]  cnt [16];
  logic [7:0]  btn_q;
  logic        cr_q;
  logic        a_bit;
  logic        b_bit;
  logic        combo;
  state_t      state;
  state_t      state_nx;
  logic [15:0] tc;
  logic [15:0] tc_nx;
  logic [16:0] tc_inc;
  logic        unused_bits;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      raw    <= '0;
      conn_q <= 1'b0;
      smp    <= 1'b0;
    end else begin
      raw    <= ~pad.pad_buttons;
      conn_q <= pad.pad_connect;
      smp    <= pad.sample_en;
    end
  end

  // A bit flips after DEB_TICKS consecutive strobes disagreeing with it.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      deb <= '0;
      for (int i = 0; i < 16; i++) cnt[i] <= '0;
    end else if (!conn_q) begin
      deb <= '0;
      for (int i = 0; i < 16; i++) cnt[i] <= '0;
    end else if (smp) begin
      for (int i = 0; i < 16; i++) begin
        if (raw[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DEB_LAST) begin
          cnt[i] <= '0;
          deb[i] <= ~deb[i];
        end else begin
          cnt[i] <= cnt[i] + 4'd1;
        end
      end
    end
  end

`ifdef PAD_CONDITIONER_TURBO_EN
  localparam logic [7:0] TURBO_LAST = 8'(TURBO_DIV - 1);

  logic       phase;
  logic [7:0] pc;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      phase <= 1'b0;
      pc    <= '0;
    end else if (!conn_q) begin
      phase <= 1'b0;
      pc    <= '0;
    end else if (smp) begin
      if (pc == TURBO_LAST) begin
        pc    <= '0;
        phase <= ~phase;
      end else begin
        pc <= pc + 8'd1;
      end
    end
  end

  assign a_bit = deb[13] | (deb[12] & phase);
  assign b_bit = deb[14] | (deb[15] & phase);
  assign unused_bits = ^deb[2:1];
`else
  assign a_bit = deb[13];
  assign b_bit = deb[14];
  assign unused_bits = ^{deb[15], deb[12], deb[2:1]}
                     ^ (TURBO_DIV == 0);
`endif

  assign combo  = &deb[11:8];
  assign tc_inc = {1'b0, tc} + 17'd1;

  always_comb begin
    state_nx = state;
    tc_nx    = tc;
    unique case (state)
      IDLE: begin
        if (combo) begin
          state_nx = ARM;
          tc_nx    = '0;
        end
      end
      ARM: begin
        if (!combo) begin
          state_nx = IDLE;
        end else if (smp) begin
          if (tc_inc == HOLD_END) begin
            state_nx = FIRE;
            tc_nx    = '0;
          end else if (tc != '1) begin
            tc_nx = tc_inc[15:0];
          end
        end
      end
      FIRE: begin
        if (smp) begin
          if (tc_inc == RST_END) begin
            state_nx = WAIT_REL;
          end else if (tc != '1) begin
            tc_nx = tc_inc[15:0];
          end
        end
      end
      WAIT_REL: begin
        if (!combo) state_nx = IDLE;
      end
    endcase
    // Losing the pad overrides any pending transition.
    if (!conn_q) begin
      state_nx = IDLE;
      tc_nx    = '0;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state <= IDLE;
      tc    <= '0;
    end else begin
      state <= state_nx;
      tc    <= tc_nx;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      btn_q <= '0;
      cr_q  <= 1'b0;
    end else if (!conn_q) begin
      btn_q <= '0;
      cr_q  <= 1'b0;
    end else begin
      btn_q <= {deb[5], deb[7], deb[6], deb[4],
                deb[3], deb[0], b_bit, a_bit};
      cr_q  <= (state == FIRE);
    end
  end

  assign pad.buttons     = btn_q;
  assign pad.connected   = conn_q;
  assign pad.combo_reset = cr_q;

endmodule

// File: tb/tb_pad_conditioner.sv
// Self-checking bench for pad_conditioner: vector table,
// hand sequences and randomized run against a strobe-level model.
module tb_pad_conditioner;

  localparam int DEB   = 4;
  localparam int HOLD  = 5;
  localparam int RST_T = 3;
  localparam int TDIV  = 2;
`ifdef PAD_CONDITIONER_TURBO_EN
  localparam bit TURBO = 1'b1;
`else
  localparam bit TURBO = 1'b0;
`endif

  typedef struct {
    logic [15:0] pad;
    logic [7:0]  exp;
  } vec_t;

  logic clk = 1'b0;
  logic n_reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pad_conditioner_if pif();

  pad_conditioner #(
    .DEB_TICKS(DEB),
    .HOLD_TICKS(HOLD),
    .RESET_TICKS(RST_T),
    .TURBO_DIV(TDIV)
  ) dut (
    .clk(clk),
    .n_reset(n_reset),
    .pad(pif.slave)
  );

  logic [15:0] mdeb;
  logic [15:0] hist[$];
  int          mk;
  bit          m_armed, m_firing, m_wait;
  int          held, fl;

  task automatic check8(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check1(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic model_clear();
    mdeb = '0;
    hist.delete();
    mk = 0;
    m_armed = 0;
    m_firing = 0;
    m_wait = 0;
    held = 0;
    fl = 0;
  endtask

  task automatic model_settle();
    bit c;
    c = &mdeb[11:8];
    if (m_wait && !c) m_wait = 0;
    if (m_armed && !c) m_armed = 0;
    else if (!m_armed && !m_firing && !m_wait && c) begin
      m_armed = 1;
      held = 0;
    end
  endtask

  task automatic model_strobe(logic [15:0] word);
    logic [15:0] flips;
    if (m_armed) begin
      held++;
      if (held == HOLD) begin
        m_armed = 0;
        m_firing = 1;
        fl = 0;
      end
    end else if (m_firing) begin
      fl++;
      if (fl == RST_T) begin
        m_firing = 0;
        m_wait = 1;
      end
    end
    hist.push_back(~word);
    if (hist.size() > DEB) void'(hist.pop_front());
    flips = '0;
    if (hist.size() == DEB) begin
      for (int b = 0; b < 16; b++) begin
        bit all;
        all = 1;
        foreach (hist[j]) if (hist[j][b] == mdeb[b]) all = 0;
        flips[b] = all;
      end
    end
    mdeb = mdeb ^ flips;
    mk++;
    model_settle();
  endtask

  function automatic logic [7:0] model_buttons();
    logic a, b, ph;
    ph = ((mk / TDIV) % 2) == 1;
    a = mdeb[13] | (TURBO & mdeb[12] & ph);
    b = mdeb[14] | (TURBO & mdeb[15] & ph);
    return {mdeb[5], mdeb[7], mdeb[6], mdeb[4],
            mdeb[3], mdeb[0], b, a};
  endfunction

  task automatic strobe();
    @(negedge clk) pif.sample_en = 1'b1;
    @(negedge clk) pif.sample_en = 1'b0;
    model_strobe(pif.pad_buttons);
    repeat (3) @(negedge clk);
  endtask

  task automatic disconnect_cycle(logic [15:0] word);
    pif.pad_connect = 1'b0;
    repeat (3) @(negedge clk);
    check8("disc_buttons", pif.buttons, 8'h00);
    check1("disc_combo", pif.combo_reset, 1'b0);
    check1("disc_conn", pif.connected, 1'b0);
    pif.pad_buttons = word;
    pif.pad_connect = 1'b1;
    repeat (3) @(negedge clk);
    model_clear();
  endtask

  task automatic combo_probe(logic [15:0] word, int n,
                             output int first, output int len);
    pif.pad_buttons = word;
    first = -1;
    len = 0;
    for (int i = 1; i <= n; i++) begin
      strobe();
      if (pif.combo_reset === 1'b1) begin
        if (first < 0) first = i;
        len++;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt[13];
    logic [7:0]  prev;
    logic [15:0] bseq[6];
    logic [7:0]  bexp[6];
    logic [15:0] word;
    int          first, len, hold_left;
    logic        exp_a;

    vt[0]  = '{16'hFFFF, 8'h00};
    vt[1]  = '{16'hDFFF, 8'h01};
    vt[2]  = '{16'hBFFF, 8'h02};
    vt[3]  = '{16'hFFFE, 8'h04};
    vt[4]  = '{16'hFFF7, 8'h08};
    vt[5]  = '{16'hFFEF, 8'h10};
    vt[6]  = '{16'hFFBF, 8'h20};
    vt[7]  = '{16'hFF7F, 8'h40};
    vt[8]  = '{16'hFFDF, 8'h80};
    vt[9]  = '{16'hDFDF, 8'h81};
    vt[10] = '{16'h9000, 8'hFF};
    vt[11] = '{16'hF0FF, 8'h00};
    vt[12] = '{16'hFFF9, 8'h00};

    pif.sample_en = 1'b0;
    pif.pad_buttons = 16'h0000;
    pif.pad_connect = 1'b1;
    model_clear();
    repeat (3) @(negedge clk);
    check8("rst_buttons", pif.buttons, 8'h00);
    check1("rst_combo", pif.combo_reset, 1'b0);
    check1("rst_conn", pif.connected, 1'b0);
    @(negedge clk) n_reset = 1'b1;
    repeat (2) @(negedge clk);
    check1("conn_after_rst", pif.connected, 1'b1);
    for (int i = 1; i <= DEB; i++) begin
      strobe();
      check8($sformatf("rst_deb_s%0d", i), pif.buttons,
             (i == DEB) ? 8'hFF : 8'h00);
    end
    disconnect_cycle(16'hFFFF);

    prev = 8'h00;
    for (int r = 0; r < 13; r++) begin
      pif.pad_buttons = vt[r].pad;
      for (int s = 1; s < DEB; s++) begin
        strobe();
        check8($sformatf("vec%0d_early%0d", r, s), pif.buttons, prev);
      end
      strobe();
      check8($sformatf("vec%0d", r), pif.buttons, vt[r].exp);
      prev = vt[r].exp;
    end
    disconnect_cycle(16'hFFFF);

    bseq = '{16'hDFFF, 16'hFFFF, 16'hDFFF,
             16'hDFFF, 16'hDFFF, 16'hDFFF};
    bexp = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
    for (int i = 0; i < 6; i++) begin
      pif.pad_buttons = bseq[i];
      strobe();
      check8($sformatf("bounce%0d", i), pif.buttons, bexp[i]);
    end
    disconnect_cycle(16'hFFFF);

    combo_probe(16'hF0FF, 32, first, len);
    check8("combo1_start", 8'(first), 8'd9);
    check8("combo1_len", 8'(len), 8'd3);
    combo_probe(16'hFFFF, 6, first, len);
    check8("combo_rel_len", 8'(len), 8'd0);
    combo_probe(16'hF0FF, 15, first, len);
    check8("combo2_start", 8'(first), 8'd9);
    check8("combo2_len", 8'(len), 8'd3);

    combo_probe(16'hFFFF, 6, first, len);
    combo_probe(16'hF0FF, DEB, first, len);
    check8("abort_arm_len", 8'(len), 8'd0);
    combo_probe(16'hF2FF, 10, first, len);
    check8("abort_len", 8'(len), 8'd0);
    combo_probe(16'hF0FF, 15, first, len);
    check8("abort_re_start", 8'(first), 8'd9);
    check8("abort_re_len", 8'(len), 8'd3);

    disconnect_cycle(16'hFFFF);
    combo_probe(16'hD0DF, 9, first, len);
    check8("disc_fire_start", 8'(first), 8'd9);
    check8("disc_fire_btn", pif.buttons, 8'h81);
    pif.pad_connect = 1'b0;
    @(negedge clk);
    check1("disc_conn_1clk", pif.connected, 1'b0);
    @(negedge clk);
    check8("disc_btn_2clk", pif.buttons, 8'h00);
    check1("disc_cr_2clk", pif.combo_reset, 1'b0);
    model_clear();
    pif.pad_connect = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 1; i <= DEB; i++) begin
      strobe();
      check8($sformatf("reconn_s%0d", i), pif.buttons,
             (i == DEB) ? 8'h81 : 8'h00);
    end

    disconnect_cycle(16'hEFFF);
    for (int k = 1; k <= 22; k++) begin
      if (k == 13) pif.pad_buttons = 16'hCFFF;
      strobe();
      exp_a = (k >= 16) |
              (TURBO & (k >= DEB) & (((k / TDIV) % 2) == 1));
      check8($sformatf("turbo_k%0d", k), pif.buttons, {7'b0, exp_a});
    end

    disconnect_cycle(16'hFFFF);
    hold_left = 0;
    word = 16'hFFFF;
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 39) == 0) begin
        disconnect_cycle(word);
        check8("rnd_disc_model", pif.buttons, model_buttons());
      end
      if (hold_left == 0) begin
        word = 16'($urandom);
        if ($urandom_range(0, 1) == 1) word[11:8] = 4'h0;
        hold_left = int'($urandom_range(1, 7));
      end
      hold_left--;
      pif.pad_buttons = word;
      strobe();
      check8($sformatf("rnd%0d_btn", it), pif.buttons, model_buttons());
      check1($sformatf("rnd%0d_cr", it), pif.combo_reset, m_firing);
      check1($sformatf("rnd%0d_conn", it), pif.connected, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
